// File: rtl/mbox_ordered_if.sv
// Handshake bundle between the xctcmsg receive mailbox and its neighbours.
// The loopback, receive-queue and writeback channels sit together in this one interface.
interface mbox_ordered_if #(
    parameter int META_W = 16,
    parameter int DATA_W = 64,
    parameter int PT_W   = 8
);
    logic              lb_valid;
    logic              lb_ready;
    logic [META_W-1:0] lb_meta;
    logic [DATA_W-1:0] lb_data;

    logic              rq_valid;
    logic              rq_ready;
    logic [META_W-1:0] rq_meta;
    logic [META_W-1:0] rq_mask;
    logic              rq_is_avail;
    logic [PT_W-1:0]   rq_pt;
    logic              csu_grant;

    logic              wb_valid;
    logic              wb_ack;
    logic [DATA_W-1:0] wb_value;
    logic [PT_W-1:0]   wb_pt;

    modport master (
        output lb_valid, lb_meta, lb_data,
        output rq_valid, rq_meta, rq_mask, rq_is_avail, rq_pt, csu_grant,
        output wb_ack,
        input  lb_ready, rq_ready, wb_valid, wb_value, wb_pt
    );

    modport slave (
        input  lb_valid, lb_meta, lb_data,
        input  rq_valid, rq_meta, rq_mask, rq_is_avail, rq_pt, csu_grant,
        input  wb_ack,
        output lb_ready, rq_ready, wb_valid, wb_value, wb_pt
    );
endinterface

// File: rtl/mbox_ordered.sv
// Receive-side mailbox: message cells with an age matrix and an in-order request queue.
// The head request resolves combinationally against the oldest matching message.
module mbox_ordered #(
    parameter int MSG_DEPTH = 4,
    parameter int REQ_DEPTH = 2,
    parameter int META_W    = 16,
    parameter int DATA_W    = 64,
    parameter int PT_W      = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    mbox_ordered_if.slave                  mb,
    output logic [$clog2(MSG_DEPTH+1)-1:0] msg_count,
    output logic [$clog2(REQ_DEPTH+1)-1:0] req_count
);
    localparam int MCW = $clog2(MSG_DEPTH + 1);
    localparam int RCW = $clog2(REQ_DEPTH + 1);
    localparam int MIW = $clog2(MSG_DEPTH);

    typedef struct packed {
        logic [META_W-1:0] meta;
        logic [META_W-1:0] mask;
        logic              is_avail;
        logic [PT_W-1:0]   pt;
    } req_t;

    logic [MSG_DEPTH-1:0] msg_vld_q, msg_vld_d;
    logic [META_W-1:0]    msg_meta_q [MSG_DEPTH];
    logic [META_W-1:0]    msg_meta_d [MSG_DEPTH];
    logic [DATA_W-1:0]    msg_data_q [MSG_DEPTH];
    logic [DATA_W-1:0]    msg_data_d [MSG_DEPTH];
    // older_q[i][j] set means cell i was allocated before cell j
    logic [MSG_DEPTH-1:0] older_q [MSG_DEPTH];
    logic [MSG_DEPTH-1:0] older_d [MSG_DEPTH];
    logic [MCW-1:0]       msg_count_q, msg_count_d;

    req_t                 req_q [REQ_DEPTH];
    req_t                 req_d [REQ_DEPTH];
    logic [RCW-1:0]       req_count_q, req_count_d;

    req_t                 head;
    req_t                 new_req;
    logic                 head_vld;
    logic [MSG_DEPTH-1:0] match;
    logic [MSG_DEPTH-1:0] sel;
    logic                 any_match;
    logic [DATA_W-1:0]    sel_data;
    logic [MIW-1:0]       alloc_idx;
    logic                 lb_ready;
    logic                 rq_ready;
    logic                 wb_valid;
    logic [DATA_W-1:0]    wb_value;
    logic                 alloc;
    logic                 retire;
    logic                 free_cell;
    logic                 push;
    int                   wr_idx;

    always_comb begin : match_select
        head     = req_q[0];
        head_vld = (req_count_q != '0);
        match    = '0;
        for (int i = 0; i < MSG_DEPTH; i++) begin
            match[i] = head_vld & msg_vld_q[i] &
                       (((msg_meta_q[i] ^ head.meta) & head.mask) == '0);
        end
        any_match = |match;
        // A matching cell wins only if it is older than every other matching cell
        sel = match;
        for (int i = 0; i < MSG_DEPTH; i++) begin
            for (int j = 0; j < MSG_DEPTH; j++) begin
                if (j != i && match[j] && !older_q[i][j]) begin
                    sel[i] = 1'b0;
                end
            end
        end
        sel_data = '0;
        for (int i = 0; i < MSG_DEPTH; i++) begin
            if (sel[i]) begin
                sel_data = sel_data | msg_data_q[i];
            end
        end
    end

    always_comb begin : resolve
        wb_valid = head_vld & (head.is_avail | any_match);
        wb_value = '0;
        if (wb_valid) begin
            wb_value = head.is_avail ? DATA_W'(any_match) : sel_data;
        end
        retire    = wb_valid & mb.wb_ack;
        free_cell = retire & ~head.is_avail;
        lb_ready  = ~&msg_vld_q;
        alloc     = mb.lb_valid & lb_ready;
        rq_ready  = mb.csu_grant & ((req_count_q != RCW'(REQ_DEPTH)) | retire);
        push      = mb.rq_valid & rq_ready & ~flush;
        alloc_idx = '0;
        for (int i = MSG_DEPTH - 1; i >= 0; i--) begin
            if (!msg_vld_q[i]) begin
                alloc_idx = MIW'(i);
            end
        end
    end

    assign mb.lb_ready = lb_ready;
    assign mb.rq_ready = rq_ready;
    assign mb.wb_valid = wb_valid;
    assign mb.wb_value = wb_value;
    assign mb.wb_pt    = head.pt;
    assign msg_count   = msg_count_q;
    assign req_count   = req_count_q;

    always_comb begin : msg_next
        msg_vld_d  = msg_vld_q;
        msg_meta_d = msg_meta_q;
        msg_data_d = msg_data_q;
        older_d    = older_q;
        if (free_cell) begin
            msg_vld_d = msg_vld_q & ~sel;
        end
        // alloc_idx comes from pre-edge valids, so it never aliases the cell being freed
        if (alloc) begin
            msg_vld_d[alloc_idx]  = 1'b1;
            msg_meta_d[alloc_idx] = mb.lb_meta;
            msg_data_d[alloc_idx] = mb.lb_data;
            older_d[alloc_idx]    = '0;
            for (int i = 0; i < MSG_DEPTH; i++) begin
                if (i != int'(alloc_idx)) begin
                    older_d[i][alloc_idx] = 1'b1;
                end
            end
        end
        msg_count_d = msg_count_q + MCW'(alloc) - MCW'(free_cell);
    end

    always_comb begin : req_next
        new_req.meta     = mb.rq_meta;
        new_req.mask     = mb.rq_mask;
        new_req.is_avail = mb.rq_is_avail;
        new_req.pt       = mb.rq_pt;
        req_d            = req_q;
        wr_idx           = int'(req_count_q) - (retire ? 1 : 0);
        if (retire) begin
            for (int i = 0; i < REQ_DEPTH - 1; i++) begin
                req_d[i] = req_q[i+1];
            end
        end
        if (push) begin
            for (int i = 0; i < REQ_DEPTH; i++) begin
                if (i == wr_idx) begin
                    req_d[i] = new_req;
                end
            end
        end
        if (flush) begin
            req_count_d = '0;
        end else begin
            req_count_d = req_count_q + RCW'(push) - RCW'(retire);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_vld_q   <= '0;
            older_q     <= '{default: '0};
            msg_count_q <= '0;
            req_count_q <= '0;
        end else begin
            msg_vld_q   <= msg_vld_d;
            older_q     <= older_d;
            msg_count_q <= msg_count_d;
            req_count_q <= req_count_d;
        end
    end

    // Payload storage carries no reset; the valid bits qualify it
    always_ff @(posedge clk) begin
        msg_meta_q <= msg_meta_d;
        msg_data_q <= msg_data_d;
        req_q      <= req_d;
    end
endmodule

// File: tb/tb_mbox_ordered.sv
// Directed bench for mbox_ordered: ordering, age matching, probes, back-pressure, flush, grant and reset.
module tb_mbox_ordered;
    localparam logic [63:0] D_A = 64'hA000_0000_0000_00A1;
    localparam logic [63:0] D_B = 64'hB000_0000_0000_00B2;
    localparam logic [63:0] D_C = 64'hC000_0000_0000_00C3;
    localparam logic [63:0] D_D = 64'hD000_0000_0000_00D4;
    localparam logic [63:0] D_E = 64'hE000_0000_0000_00E5;
    localparam logic [63:0] D_F = 64'hF000_0000_0000_00F6;
    localparam logic [63:0] D_M = 64'h1234_5678_9ABC_DEF0;
    localparam logic [63:0] D_G = 64'h0BAD_F00D_0000_0007;
    localparam logic [63:0] D_Y = 64'h5555_AAAA_5555_AAAA;
    localparam logic [63:0] D_Z = 64'h0000_0000_0000_0099;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic [2:0] msg_count;
    logic [1:0] req_count;
    int         vectors = 0;
    int         miscompares = 0;

    mbox_ordered_if #(.META_W(16), .DATA_W(64), .PT_W(8)) mb ();

    mbox_ordered #(
        .MSG_DEPTH(4), .REQ_DEPTH(2), .META_W(16), .DATA_W(64), .PT_W(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .mb        (mb),
        .msg_count (msg_count),
        .req_count (req_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_msg(input logic [15:0] meta, input logic [63:0] data);
        mb.lb_valid = 1'b1;
        mb.lb_meta  = meta;
        mb.lb_data  = data;
        step();
        mb.lb_valid = 1'b0;
        #1;
    endtask

    task automatic put_req(input logic [15:0] meta, input logic [15:0] mask,
                           input logic avail, input logic [7:0] pt);
        mb.rq_valid    = 1'b1;
        mb.rq_meta     = meta;
        mb.rq_mask     = mask;
        mb.rq_is_avail = avail;
        mb.rq_pt       = pt;
        step();
        mb.rq_valid = 1'b0;
        #1;
    endtask

    task automatic ack_head();
        mb.wb_ack = 1'b1;
        step();
        mb.wb_ack = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        vectors++; if (mb.lb_ready !== 1'b1) begin miscompares++; $display("FAIL reset_lb_ready got %b want 1", mb.lb_ready); end
        vectors++; if (mb.rq_ready !== 1'b1) begin miscompares++; $display("FAIL reset_rq_ready got %b want 1", mb.rq_ready); end
        vectors++; if (mb.wb_valid !== 1'b0) begin miscompares++; $display("FAIL reset_wb_valid got %b want 0", mb.wb_valid); end
        vectors++; if (mb.wb_value !== 64'd0) begin miscompares++; $display("FAIL reset_wb_value got %h want 0", mb.wb_value); end
        vectors++; if (msg_count !== 3'd0) begin miscompares++; $display("FAIL reset_msg_count got %0d want 0", msg_count); end
        vectors++; if (req_count !== 2'd0) begin miscompares++; $display("FAIL reset_req_count got %0d want 0", req_count); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_order();
        put_msg(16'h11, D_A);
        put_msg(16'h11, D_B);
        put_msg(16'h22, D_C);
        vectors++; if (msg_count !== 3'd3) begin miscompares++; $display("FAIL order_count3 got %0d want 3", msg_count); end
        put_req(16'h11, 16'hFF, 1'b0, 8'h5A);
        vectors++; if (req_count !== 2'd1) begin miscompares++; $display("FAIL order_req_count got %0d want 1", req_count); end
        vectors++; if (mb.wb_valid !== 1'b1) begin miscompares++; $display("FAIL order_wb_valid got %b want 1", mb.wb_valid); end
        vectors++; if (mb.wb_value !== D_A) begin miscompares++; $display("FAIL order_first got %h want %h", mb.wb_value, D_A); end
        vectors++; if (mb.wb_pt !== 8'h5A) begin miscompares++; $display("FAIL order_pt got %h want 5a", mb.wb_pt); end
        ack_head();
        vectors++; if (msg_count !== 3'd2) begin miscompares++; $display("FAIL order_count2 got %0d want 2", msg_count); end
        vectors++; if (req_count !== 2'd0) begin miscompares++; $display("FAIL order_req_pop got %0d want 0", req_count); end
        vectors++; if (mb.wb_valid !== 1'b0) begin miscompares++; $display("FAIL order_idle_valid got %b want 0", mb.wb_valid); end
        put_req(16'h11, 16'hFF, 1'b0, 8'h5B);
        vectors++; if (mb.wb_value !== D_B) begin miscompares++; $display("FAIL order_second got %h want %h", mb.wb_value, D_B); end
        ack_head();
        vectors++; if (msg_count !== 3'd1) begin miscompares++; $display("FAIL order_count1 got %0d want 1", msg_count); end
    endtask

    task automatic test_age();
        put_msg(16'h44, D_D);
        put_msg(16'h55, D_E);
        put_req(16'h44, 16'hFF, 1'b0, 8'h01);
        vectors++; if (mb.wb_value !== D_D) begin miscompares++; $display("FAIL age_d got %h want %h", mb.wb_value, D_D); end
        ack_head();
        put_msg(16'h55, D_F);
        put_req(16'h55, 16'hFF, 1'b0, 8'h02);
        vectors++; if (mb.wb_value !== D_E) begin miscompares++; $display("FAIL age_oldest got %h want %h", mb.wb_value, D_E); end
        ack_head();
        put_req(16'h55, 16'hFF, 1'b0, 8'h03);
        vectors++; if (mb.wb_value !== D_F) begin miscompares++; $display("FAIL age_younger got %h want %h", mb.wb_value, D_F); end
        ack_head();
        vectors++; if (msg_count !== 3'd1) begin miscompares++; $display("FAIL age_count got %0d want 1", msg_count); end
    endtask

    task automatic test_avail();
        put_req(16'h22, 16'hFF, 1'b1, 8'h10);
        vectors++; if (mb.wb_valid !== 1'b1) begin miscompares++; $display("FAIL avail_hit_valid got %b want 1", mb.wb_valid); end
        vectors++; if (mb.wb_value !== 64'd1) begin miscompares++; $display("FAIL avail_hit_value got %h want 1", mb.wb_value); end
        vectors++; if (mb.wb_pt !== 8'h10) begin miscompares++; $display("FAIL avail_pt got %h want 10", mb.wb_pt); end
        ack_head();
        vectors++; if (msg_count !== 3'd1) begin miscompares++; $display("FAIL avail_nonconsume got %0d want 1", msg_count); end
        put_req(16'h33, 16'hFF, 1'b1, 8'h11);
        vectors++; if (mb.wb_valid !== 1'b1) begin miscompares++; $display("FAIL avail_miss_valid got %b want 1", mb.wb_valid); end
        vectors++; if (mb.wb_value !== 64'd0) begin miscompares++; $display("FAIL avail_miss_value got %h want 0", mb.wb_value); end
        ack_head();
        put_req(16'h32, 16'h0F, 1'b1, 8'h12);
        vectors++; if (mb.wb_value !== 64'd1) begin miscompares++; $display("FAIL avail_mask got %h want 1", mb.wb_value); end
        ack_head();
    endtask

    task automatic test_full();
        put_msg(16'h60, D_M);
        put_msg(16'h61, D_E);
        put_msg(16'h63, D_F);
        vectors++; if (msg_count !== 3'd4) begin miscompares++; $display("FAIL full_count got %0d want 4", msg_count); end
        vectors++; if (mb.lb_ready !== 1'b0) begin miscompares++; $display("FAIL full_lb_ready got %b want 0", mb.lb_ready); end
        put_req(16'h60, 16'hFF, 1'b0, 8'h20);
        vectors++; if (mb.wb_value !== D_M) begin miscompares++; $display("FAIL full_head got %h want %h", mb.wb_value, D_M); end
        mb.wb_ack   = 1'b1;
        mb.lb_valid = 1'b1;
        mb.lb_meta  = 16'h70;
        mb.lb_data  = D_G;
        #1;
        vectors++; if (mb.lb_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready_same_cycle got %b want 0", mb.lb_ready); end
        step();
        mb.wb_ack   = 1'b0;
        mb.lb_valid = 1'b0;
        #1;
        vectors++; if (msg_count !== 3'd3) begin miscompares++; $display("FAIL full_no_alloc got %0d want 3", msg_count); end
        vectors++; if (mb.lb_ready !== 1'b1) begin miscompares++; $display("FAIL full_ready_next got %b want 1", mb.lb_ready); end
        put_msg(16'h70, D_G);
        put_req(16'h70, 16'hFF, 1'b0, 8'h21);
        vectors++; if (mb.wb_value !== D_G) begin miscompares++; $display("FAIL full_realloc got %h want %h", mb.wb_value, D_G); end
        ack_head();
        vectors++; if (msg_count !== 3'd3) begin miscompares++; $display("FAIL full_after got %0d want 3", msg_count); end
    endtask

    task automatic test_back_to_back();
        put_req(16'h99, 16'hFF, 1'b0, 8'h01);
        put_req(16'h99, 16'hFF, 1'b0, 8'h02);
        vectors++; if (req_count !== 2'd2) begin miscompares++; $display("FAIL b2b_req_count got %0d want 2", req_count); end
        mb.rq_valid = 1'b1;
        mb.rq_meta  = 16'h99;
        mb.rq_pt    = 8'h03;
        #1;
        vectors++; if (mb.rq_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_rq_ready_full got %b want 0", mb.rq_ready); end
        repeat (3) step();
        vectors++; if (req_count !== 2'd2) begin miscompares++; $display("FAIL b2b_no_push got %0d want 2", req_count); end
        vectors++; if (mb.wb_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_blocked got %b want 0", mb.wb_valid); end
        mb.rq_valid = 1'b0;
        put_msg(16'h99, D_Y);
        vectors++; if (mb.wb_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_resolve got %b want 1", mb.wb_valid); end
        vectors++; if (mb.wb_value !== D_Y) begin miscompares++; $display("FAIL b2b_value got %h want %h", mb.wb_value, D_Y); end
        vectors++; if (mb.wb_pt !== 8'h01) begin miscompares++; $display("FAIL b2b_pt1 got %h want 01", mb.wb_pt); end
        mb.wb_ack   = 1'b1;
        mb.rq_valid = 1'b1;
        #1;
        vectors++; if (mb.rq_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_retire got %b want 1", mb.rq_ready); end
        step();
        mb.wb_ack   = 1'b0;
        mb.rq_valid = 1'b0;
        #1;
        vectors++; if (req_count !== 2'd2) begin miscompares++; $display("FAIL b2b_pushpop got %0d want 2", req_count); end
        vectors++; if (mb.wb_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_second_waits got %b want 0", mb.wb_valid); end
        vectors++; if (mb.wb_pt !== 8'h02) begin miscompares++; $display("FAIL b2b_pt2 got %h want 02", mb.wb_pt); end
        vectors++; if (msg_count !== 3'd3) begin miscompares++; $display("FAIL b2b_msg_count got %0d want 3", msg_count); end
    endtask

    task automatic test_flush();
        put_msg(16'h99, D_Z);
        vectors++; if (mb.wb_value !== D_Z) begin miscompares++; $display("FAIL flush_head got %h want %h", mb.wb_value, D_Z); end
        vectors++; if (msg_count !== 3'd4) begin miscompares++; $display("FAIL flush_pre_count got %0d want 4", msg_count); end
        flush       = 1'b1;
        mb.wb_ack   = 1'b1;
        mb.rq_valid = 1'b1;
        mb.rq_pt    = 8'h04;
        step();
        flush       = 1'b0;
        mb.wb_ack   = 1'b0;
        mb.rq_valid = 1'b0;
        #1;
        vectors++; if (req_count !== 2'd0) begin miscompares++; $display("FAIL flush_req_count got %0d want 0", req_count); end
        vectors++; if (msg_count !== 3'd3) begin miscompares++; $display("FAIL flush_freed got %0d want 3", msg_count); end
        vectors++; if (mb.wb_valid !== 1'b0) begin miscompares++; $display("FAIL flush_wb_valid got %b want 0", mb.wb_valid); end
        put_req(16'h22, 16'hFF, 1'b1, 8'h30);
        vectors++; if (req_count !== 2'd1) begin miscompares++; $display("FAIL flush_new_req got %0d want 1", req_count); end
        vectors++; if (mb.wb_value !== 64'd1) begin miscompares++; $display("FAIL flush_new_value got %h want 1", mb.wb_value); end
        vectors++; if (mb.wb_pt !== 8'h30) begin miscompares++; $display("FAIL flush_new_pt got %h want 30", mb.wb_pt); end
        ack_head();
    endtask

    task automatic test_grant();
        mb.csu_grant   = 1'b0;
        mb.rq_valid    = 1'b1;
        mb.rq_is_avail = 1'b1;
        mb.rq_meta     = 16'h22;
        #1;
        vectors++; if (mb.rq_ready !== 1'b0) begin miscompares++; $display("FAIL grant_low_ready got %b want 0", mb.rq_ready); end
        step();
        mb.rq_valid = 1'b0;
        #1;
        vectors++; if (req_count !== 2'd0) begin miscompares++; $display("FAIL grant_low_push got %0d want 0", req_count); end
        mb.csu_grant = 1'b1;
        #1;
        vectors++; if (mb.rq_ready !== 1'b1) begin miscompares++; $display("FAIL grant_high_ready got %b want 1", mb.rq_ready); end
    endtask

    task automatic test_async_reset();
        put_req(16'h22, 16'hFF, 1'b1, 8'h40);
        vectors++; if (mb.wb_valid !== 1'b1) begin miscompares++; $display("FAIL arst_pre_valid got %b want 1", mb.wb_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (mb.wb_valid !== 1'b0) begin miscompares++; $display("FAIL arst_wb_valid got %b want 0", mb.wb_valid); end
        vectors++; if (mb.wb_value !== 64'd0) begin miscompares++; $display("FAIL arst_wb_value got %h want 0", mb.wb_value); end
        vectors++; if (msg_count !== 3'd0) begin miscompares++; $display("FAIL arst_msg_count got %0d want 0", msg_count); end
        vectors++; if (req_count !== 2'd0) begin miscompares++; $display("FAIL arst_req_count got %0d want 0", req_count); end
        vectors++; if (mb.lb_ready !== 1'b1) begin miscompares++; $display("FAIL arst_lb_ready got %b want 1", mb.lb_ready); end
        step();
        rst_n = 1'b1;
        step();
        vectors++; if (msg_count !== 3'd0) begin miscompares++; $display("FAIL arst_after got %0d want 0", msg_count); end
    endtask

    initial begin
        rst_n          = 1'b0;
        flush          = 1'b0;
        mb.lb_valid    = 1'b0;
        mb.lb_meta     = '0;
        mb.lb_data     = '0;
        mb.rq_valid    = 1'b0;
        mb.rq_meta     = '0;
        mb.rq_mask     = 16'hFF;
        mb.rq_is_avail = 1'b0;
        mb.rq_pt       = '0;
        mb.csu_grant   = 1'b1;
        mb.wb_ack      = 1'b0;
        test_reset();
        test_order();
        test_age();
        test_avail();
        test_full();
        test_back_to_back();
        test_flush();
        test_grant();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
